fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Program counter and instruction-fetch stage feeding the control decoder.
//  Drives a synchronous-read instruction ROM and presents one instruction per
//  cycle with a valid qualifier. Redirects the PC on taken branches and
//  squashes the wrong-path slot. Implements the Start/Done program handshake
//  and keeps a run-cycle counter.
// PARAMETERS
//  PC_W          10      program counter / ROM address width
//  INSTR_W       9       instruction width
//  BUBBLE_INSTR  9'h000  encoding driven on Instr while InstrValid=0
// PORTS
//  Clk         in   1        clock
//  Reset       in   1        asynchronous active-high reset
//  Start       in   1        level; high = hold PC at 0; falling edge starts run
//  Stall       in   1        freeze fetch and decode slot
//  BranchEn    in   1        from decoder: current Instr is a branch
//  Taken       in   1        ALU condition flag
//  BranchRel   in   1        1 = Target is signed offset from DecPC, 0 = absolute
//  Target      in   PC_W     branch target or offset
//  Ack         in   1        from decoder: halt instruction in decode
//  RomAddr     out  PC_W     ROM read address (= PC register)
//  InstrIn     in   INSTR_W  ROM data, = mem[RomAddr of previous cycle]
//  Instr       out  INSTR_W  instruction to decoder
//  InstrValid  out  1        Instr is real (downstream gates writes with it)
//  DecPC       out  PC_W     address of Instr
//  Done        out  1        program finished
//  CycleCount  out  32       cycles spent in RUN
// BEHAVIOUR
//  Reset: state=IDLE, PC=0, DecPC=0, InstrValid=0, Done=0, CycleCount=0,
//   Instr=BUBBLE_INSTR.
//  FSM IDLE/LOAD/RUN/DONE.
//   IDLE: Start=1 -> LOAD.
//   LOAD: PC=0, CycleCount=0, InstrValid=0, Done=0; Start=0 -> RUN.
//   RUN:  Start=1 -> LOAD (restart, overrides all else).
//    Ack&InstrValid&!Stall -> DONE.
//   DONE: Done=1, PC/CycleCount frozen, InstrValid=0; Start=1 -> LOAD.
//  Pipeline in RUN:
//   - Each non-stall cycle: DecPC<=PC, InstrValid<=1 unless squashed, PC<=next.
//   - First RUN cycle: RomAddr=0. Instr of addr 0 is valid the next cycle.
//  Branch:
//   - Taken when BranchEn&Taken&InstrValid&!Stall.
//   - next PC = BranchRel ? DecPC+sext(Target) : Target.
//   - The slot fetched in that cycle (DecPC+1) is squashed: InstrValid=0 next
//     cycle, one bubble. The target instruction is valid two cycles after the
//     branch decode.
//  Stall:
//   - First stall cycle captures Instr into a hold register.
//   - While stalled: Instr/InstrValid/DecPC are unchanged and come from the hold
//     register; PC and RomAddr are held.
//   - On release, the held instruction is consumed. The ROM re-reads PC, so no
//     slot is lost or duplicated.
//   - Stall overrides branch and Ack; both act in the first non-stall cycle.
//  Arithmetic: PC+1 and relative targets wrap modulo 2^PC_W, no flag.
//  CycleCount: +1 each RUN cycle including stalls, saturates at 2^32-1.
//  Reset mid-run returns to IDLE immediately; a taken branch in the same cycle
//   as Start=1 is ignored.
// TESTING
//  1. Reset, Start 1 for 2 cycles then 0, ROM=sequential NOPs
//     -> Instr valid from addr 0, DecPC 0,1,2...; CycleCount counts.
//  2. Absolute taken branch at addr 5, Target=40
//     -> one bubble (InstrValid=0), next valid DecPC=40.
//  3. Relative branch at 20, Target=-4 (10'h3FC), Taken=1
//     -> next valid DecPC=16. Same with Taken=0 -> DecPC=21, no bubble.
//  4. Stall 3 cycles while Instr at addr 7 -> Instr/DecPC=7 held throughout;
//     after release DecPC 8 follows with no skipped or duplicated address.
//  5. Ack at addr 12 -> Done=1 next cycle, PC and CycleCount frozen;
//     Start pulse -> Done=0, run restarts at 0.
//  6. Reset asserted mid-branch -> all outputs at reset values asynchronously;
//     PC=1023 with no branch -> wraps to 0.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : fetch_unit
// Brief   : Program counter and instruction-fetch stage with branch redirect,
//           wrong-path squash, stall hold register and Start/Done handshake.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int                 PC_W         = 10,
    parameter int                 INSTR_W      = 9,
    parameter logic [INSTR_W-1:0] BUBBLE_INSTR = '0
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Stall,
    input  logic               BranchEn,
    input  logic               Taken,
    input  logic               BranchRel,
    input  logic [PC_W-1:0]    Target,
    input  logic               Ack,
    output logic [PC_W-1:0]    RomAddr,
    input  logic [INSTR_W-1:0] InstrIn,
    output logic [INSTR_W-1:0] Instr,
    output logic               InstrValid,
    output logic [PC_W-1:0]    DecPC,
    output logic               Done,
    output logic [31:0]        CycleCount
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [PC_W-1:0] c_pc_one  = PC_W'(1);
    localparam logic [31:0]     c_cnt_max = 32'hFFFF_FFFF;

    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic [PC_W-1:0]    r_pc;
    logic [PC_W-1:0]    r_decpc;
    logic               r_valid;
    logic               r_done;
    logic [31:0]        r_cnt;
    logic               r_held;
    logic [INSTR_W-1:0] r_hold;

    logic               w_taken;
    logic [PC_W-1:0]    w_target;
    logic [PC_W-1:0]    w_pc_next;
    logic [INSTR_W-1:0] w_instr;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (Start) w_next = S_LOAD;
            S_LOAD: if (!Start) w_next = S_RUN;
            S_RUN: begin
                if (Start) begin
                    w_next = S_LOAD;
                end else if (Ack && r_valid && !Stall) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: if (Start) w_next = S_LOAD;
            default: w_next = S_IDLE;
        endcase
    end

    // Relative targets wrap naturally in PC_W bits; the offset already spans PC_W.
    assign w_taken   = BranchEn && Taken && r_valid && !Stall;
    assign w_target  = BranchRel ? (r_decpc + Target) : Target;
    assign w_pc_next = w_taken ? w_target : (r_pc + c_pc_one);

    // ROM data lines up with DecPC only on the cycle after an advance; after that the hold register owns the slot.
    assign w_instr = r_held  ? r_hold :
                     r_valid ? InstrIn : BUBBLE_INSTR;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_pc    <= '0;
            r_decpc <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_held  <= 1'b0;
            r_hold  <= BUBBLE_INSTR;
        end else if (w_next == S_LOAD) begin
            r_pc    <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_held  <= 1'b0;
        end else if (r_state == S_RUN) begin
            if (r_cnt != c_cnt_max) begin
                r_cnt <= r_cnt + 32'd1;
            end
            if (w_next == S_DONE) begin
                r_done  <= 1'b1;
                r_valid <= 1'b0;
                r_held  <= 1'b0;
            end else if (Stall) begin
                r_held <= 1'b1;
                if (!r_held) begin
                    r_hold <= w_instr;
                end
            end else begin
                r_held  <= 1'b0;
                r_decpc <= r_pc;
                r_valid <= !w_taken;
                r_pc    <= w_pc_next;
            end
        end
    end

    assign RomAddr    = r_pc;
    assign Instr      = w_instr;
    assign InstrValid = r_valid;
    assign DecPC      = r_decpc;
    assign Done       = r_done;
    assign CycleCount = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_fetch_unit
// Brief   : Directed plus randomized bench for fetch_unit against a
//           program-level reference model and a behavioural ROM.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 9;
    localparam int PC_MASK = (1 << PC_W) - 1;

    logic               Clk = 1'b0;
    logic               Reset = 1'b1;
    logic               Start = 1'b0;
    logic               Stall = 1'b0;
    logic               BranchEn = 1'b0;
    logic               Taken = 1'b0;
    logic               BranchRel = 1'b0;
    logic [PC_W-1:0]    Target = '0;
    logic               Ack = 1'b0;
    logic [PC_W-1:0]    RomAddr;
    logic [INSTR_W-1:0] InstrIn = '0;
    logic [INSTR_W-1:0] Instr;
    logic               InstrValid;
    logic [PC_W-1:0]    DecPC;
    logic               Done;
    logic [31:0]        CycleCount;

    fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .BUBBLE_INSTR(9'h000)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall),
        .BranchEn(BranchEn), .Taken(Taken), .BranchRel(BranchRel),
        .Target(Target), .Ack(Ack), .RomAddr(RomAddr), .InstrIn(InstrIn),
        .Instr(Instr), .InstrValid(InstrValid), .DecPC(DecPC), .Done(Done),
        .CycleCount(CycleCount)
    );

    always #5 Clk = ~Clk;

    logic [INSTR_W-1:0] mem [0:(1<<PC_W)-1];
    always @(posedge Clk) InstrIn <= mem[RomAddr];

    int total = 0;
    int bad   = 0;

    // Program-level model: mode 0 idle, 1 load, 2 run, 3 done.
    int          m_mode, m_pc, m_decpc;
    bit          m_valid, m_done;
    longint      m_cnt;

    task automatic model_reset();
        m_mode = 0; m_pc = 0; m_decpc = 0; m_valid = 0; m_done = 0; m_cnt = 0;
    endtask

    task automatic model_clear();
        m_mode = 1; m_pc = 0; m_valid = 0; m_done = 0; m_cnt = 0;
    endtask

    task automatic model_step();
        int nxt;
        bit br;
        case (m_mode)
            0: if (Start) model_clear();
            1: if (Start) model_clear(); else m_mode = 2;
            2: begin
                if (Start) begin
                    model_clear();
                end else begin
                    if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
                    if (!Stall) begin
                        if (Ack && m_valid) begin
                            m_mode = 3; m_done = 1; m_valid = 0;
                        end else begin
                            br  = BranchEn && Taken && m_valid;
                            nxt = br ? (BranchRel ? (m_decpc + int'(Target)) : int'(Target))
                                     : (m_pc + 1);
                            m_decpc = m_pc;
                            m_valid = !br;
                            m_pc    = nxt & PC_MASK;
                        end
                    end
                end
            end
            default: if (Start) model_clear();
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [INSTR_W-1:0] exp_instr;
        exp_instr = m_valid ? mem[m_decpc] : '0;
        chk("romaddr", 32'(RomAddr), 32'(m_pc));
        chk("decpc",   32'(DecPC),   32'(m_decpc));
        chk("valid",   32'(InstrValid), 32'(m_valid));
        chk("instr",   32'(Instr),   32'(exp_instr));
        chk("done",    32'(Done),    32'(m_done));
        chk("count",   CycleCount,   m_cnt[31:0]);
    endtask

    task automatic cyc(input bit st, input bit sl, input bit be, input bit tk,
                       input bit rel, input logic [PC_W-1:0] tg, input bit ak);
        @(negedge Clk);
        Reset = 0; Start = st; Stall = sl; BranchEn = be; Taken = tk;
        BranchRel = rel; Target = tg; Ack = ak;
        @(posedge Clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, '0, 0);
    endtask

    task automatic wait_pc(input int a);
        for (int i = 0; i < 80 && !(m_valid && m_decpc == a); i++) idle(1);
        chk("reach_pc", 32'(DecPC), 32'(a));
        chk("reach_valid", 32'(InstrValid), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < (1 << PC_W); i++) mem[i] = INSTR_W'($urandom);
        model_reset();
        #3;
        check_all();

        // Start held for two cycles, then run from address 0
        cyc(1, 0, 0, 0, 0, '0, 0);
        cyc(1, 0, 0, 0, 0, '0, 0);
        idle(2);
        chk("first_decpc", 32'(DecPC), 32'd0);
        chk("first_valid", 32'(InstrValid), 32'd1);
        idle(3);

        // Absolute taken branch at 5 to 40
        wait_pc(5);
        cyc(0, 0, 1, 1, 0, 10'd40, 0);
        chk("abs_bubble", 32'(InstrValid), 32'd0);
        idle(1);
        chk("abs_target", 32'(DecPC), 32'd40);
        chk("abs_valid", 32'(InstrValid), 32'd1);

        // Relative branch at 20 by -4, then not-taken at 20
        cyc(0, 0, 1, 1, 0, 10'd18, 0);
        wait_pc(20);
        cyc(0, 0, 1, 1, 1, 10'h3FC, 0);
        idle(1);
        chk("rel_target", 32'(DecPC), 32'd16);
        wait_pc(20);
        cyc(0, 0, 1, 0, 1, 10'h3FC, 0);
        chk("nt_decpc", 32'(DecPC), 32'd21);
        chk("nt_valid", 32'(InstrValid), 32'd1);

        // Stall three cycles on address 7
        cyc(0, 0, 1, 1, 0, 10'd7, 0);
        wait_pc(7);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 1, 1, 0, 10'd99, 1);
            chk("stall_decpc", 32'(DecPC), 32'd7);
            chk("stall_instr", 32'(Instr), 32'(mem[7]));
        end
        idle(1);
        chk("release_decpc", 32'(DecPC), 32'd8);
        chk("release_instr", 32'(Instr), 32'(mem[8]));

        // Ack at 12, then restart
        wait_pc(12);
        cyc(0, 0, 0, 0, 0, '0, 1);
        chk("done_set", 32'(Done), 32'd1);
        idle(3);
        cyc(1, 0, 0, 0, 0, '0, 0);
        chk("done_clr", 32'(Done), 32'd0);
        chk("cnt_clr", CycleCount, 32'd0);
        idle(2);
        chk("restart_decpc", 32'(DecPC), 32'd0);

        // Asynchronous reset during a taken branch
        wait_pc(3);
        @(negedge Clk);
        Stall = 0; BranchEn = 1; Taken = 1; BranchRel = 0; Target = 10'd100;
        #2 Reset = 1;
        #1 model_reset();
        check_all();
        @(posedge Clk);
        #1 check_all();

        // PC wrap from 1023 to 0
        cyc(1, 0, 0, 0, 0, '0, 0);
        idle(3);
        wait_pc(2);
        cyc(0, 0, 1, 1, 0, 10'd1022, 0);
        wait_pc(1023);
        idle(1);
        chk("wrap_decpc", 32'(DecPC), 32'd0);
        chk("wrap_valid", 32'(InstrValid), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, PC_W'($urandom), ($urandom_range(0, 29) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
